hi_lo_muldiv_unit: RTL and testbench

HI_LO_MULDIV_UNIT -- requirements
Module: hi_lo_muldiv_unit

---
 rtl/hi_lo_muldiv_unit_pkg.sv | 13 +
 rtl/hi_lo_muldiv_unit_datapath.sv | 57 +++++
 rtl/hi_lo_muldiv_unit.sv | 86 ++++++++
 tb/tb_hi_lo_muldiv_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hi_lo_muldiv_unit_pkg.sv
// hi_lo_muldiv_unit_pkg: shared OP codes, FSM states and width defaults for the HI/LO multiply/divide unit
package hi_lo_muldiv_unit_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_MUL = 2'b01, S_DIV = 2'b10, S_FIX = 2'b11} state_e;
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction
  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction
endpackage

// File: rtl/hi_lo_muldiv_unit_datapath.sv
// muldiv_datapath: 2*WIDTH accumulator, shift-add / restoring shift-subtract step and sign fixup (in: clk,rst,i_load,i_op,i_a,i_b,i_mul_step,i_div_step; out: o_hi,o_lo)
module muldiv_datapath
  import hi_lo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mul_step,
  input  logic             i_div_step,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_div, r_neg_q, r_neg_r;
  logic               w_sa, w_sb, w_ge;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_diff;
  logic [WIDTH:0]     w_add, w_sh;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  assign w_sa = op_is_signed(i_op) && i_a[WIDTH-1];
  assign w_sb = op_is_signed(i_op) && i_b[WIDTH-1];
  assign w_mag_a = w_sa ? -i_a : i_a;
  assign w_mag_b = w_sb ? -i_b : i_b;
  assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b & {WIDTH{r_acc[0]}}};
  assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};
  assign w_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge = w_sh >= {1'b0, r_b};
  assign w_diff = w_sh[WIDTH-1:0] - r_b;
  assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1} : {w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign o_lo = r_div ? (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]) : w_prod[WIDTH-1:0];
  assign o_hi = r_div ? (r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH]) : w_prod[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_b <= '0;
      r_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, w_mag_a};
      r_b <= w_mag_b;
      r_div <= op_is_div(i_op);
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end else if (i_mul_step) begin
      r_acc <= w_mul_next;
    end else if (i_div_step) begin
      r_acc <= w_div_next;
    end
  end
endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit: MIPS-style HI/LO multiply/divide unit (in: CLK,RST,START,OP,SRC_A,SRC_B,MT_DATA,hi_SEL,hi_EN,lo_SEL,lo_EN; out: BUSY,DONE,DIV0,HI_OUT,LO_OUT)
module hi_lo_muldiv_unit
  import hi_lo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic [WIDTH-1:0] MT_DATA,
  input  logic             hi_SEL,
  input  logic             hi_EN,
  input  logic             lo_SEL,
  input  logic             lo_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV0,
  output logic [WIDTH-1:0] HI_OUT,
  output logic [WIDTH-1:0] LO_OUT
);
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, w_hi, w_lo;
  logic             r_done, r_div0, r_zero;
  logic             w_load;
  assign w_load = r_state == S_IDLE && START;
  assign BUSY = r_state != S_IDLE;
  assign DONE = r_done;
  assign DIV0 = r_div0;
  assign HI_OUT = r_hi;
  assign LO_OUT = r_lo;
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (CLK),
    .rst        (RST),
    .i_load     (w_load),
    .i_op       (OP),
    .i_a        (SRC_A),
    .i_b        (SRC_B),
    .i_mul_step (r_state == S_MUL),
    .i_div_step (r_state == S_DIV),
    .o_hi       (w_hi),
    .o_lo       (w_lo)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_EN && !hi_SEL) r_hi <= MT_DATA;
          if (lo_EN && !lo_SEL) r_lo <= MT_DATA;
          if (START) begin
            r_cnt <= '0;
            r_zero <= op_is_div(OP) && SRC_B == '0;
            r_state <= !op_is_div(OP) ? S_MUL : (SRC_B == '0 ? S_FIX : S_DIV);
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
        end
        default: begin
          if (!r_zero) begin
            r_hi <= w_hi;
            r_lo <= w_lo;
          end
          r_done <= 1'b1;
          r_div0 <= r_zero;
          r_cnt <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// tb_hi_lo_muldiv_unit: scoreboard bench for hi_lo_muldiv_unit against an arithmetic reference model
module tb_hi_lo_muldiv_unit;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           cyc;
  } exp_t;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [W-1:0] SRC_A = '0;
  logic [W-1:0] SRC_B = '0;
  logic [W-1:0] MT_DATA = '0;
  logic         hi_SEL = 1'b0;
  logic         hi_EN = 1'b0;
  logic         lo_SEL = 1'b0;
  logic         lo_EN = 1'b0;
  logic         BUSY, DONE, DIV0;
  logic [W-1:0] HI_OUT, LO_OUT;
  exp_t         q[$];
  exp_t         m_e;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  hi_lo_muldiv_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .SRC_A(SRC_A), .SRC_B(SRC_B),
    .MT_DATA(MT_DATA), .hi_SEL(hi_SEL), .hi_EN(hi_EN), .lo_SEL(lo_SEL), .lo_EN(lo_EN),
    .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] ohi, input logic [W-1:0] olo);
    exp_t e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p;
    e.div0 = 1'b0;
    e.cyc = 0;
    e.hi = ohi;
    e.lo = olo;
    if (op == 2'b00) begin
      p = 64'(sa * sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (op == 2'b01) begin
      p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.div0 = 1'b1;
    end else if (op == 2'b10) begin
      e.lo = 32'(sa / sb);
      e.hi = 32'(sa % sb);
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction
  always @(negedge CLK) begin
    if (!RST) begin
      if (DONE) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: got DONE=1 expected no pending operation (cycle %0d)", cyc);
        end else begin
          m_e = q.pop_front();
          chk("done_hi", HI_OUT, m_e.hi);
          chk("done_lo", LO_OUT, m_e.lo);
          chk("done_div0", DIV0, m_e.div0);
          chk("done_latency", cyc, m_e.cyc);
          chk("done_busy", BUSY, 0);
        end
      end else if (DIV0) begin
        n_chk++;
        n_fail++;
        $display("FAIL div0_without_done: got DIV0=1 expected 0 (cycle %0d)", cyc);
      end
    end
  end
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic he = 0, input logic hs = 0, input logic le = 0,
                          input logic ls = 0, input logic [W-1:0] mt = 0);
    exp_t e;
    OP = op; SRC_A = a; SRC_B = b; START = 1'b1;
    hi_EN = he; hi_SEL = hs; lo_EN = le; lo_SEL = ls; MT_DATA = mt;
    if (he && !hs) m_hi = mt;
    if (le && !ls) m_lo = mt;
    e = model(op, a, b, m_hi, m_lo);
    e.cyc = cyc + (e.div0 ? 2 : W + 2);
    m_hi = e.hi;
    m_lo = e.lo;
    q.push_back(e);
    @(posedge CLK); #1;
    START = 1'b0; hi_EN = 1'b0; lo_EN = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (!DONE && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    if (!DONE) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no DONE within %0d cycles expected DONE", k);
    end
  endtask
  task automatic mt_write(input logic he, input logic hs, input logic le, input logic ls, input logic [W-1:0] d);
    hi_EN = he; hi_SEL = hs; lo_EN = le; lo_SEL = ls; MT_DATA = d;
    if (he && !hs) m_hi = d;
    if (le && !ls) m_lo = d;
    @(posedge CLK); #1;
    hi_EN = 1'b0; lo_EN = 1'b0;
    chk("mt_hi", HI_OUT, m_hi);
    chk("mt_lo", LO_OUT, m_lo);
  endtask
  task automatic noise();
    START = 1'b1; OP = 2'($urandom_range(0, 3)); SRC_A = 32'($urandom); SRC_B = 32'($urandom);
    hi_EN = 1'b1; hi_SEL = 1'b0; lo_EN = 1'b1; lo_SEL = 1'b0; MT_DATA = 32'($urandom);
    @(posedge CLK); #1;
    START = 1'b0; hi_EN = 1'b0; lo_EN = 1'b0;
    chk("busy_hold", BUSY, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_div0", DIV0, 0);
    chk("rst_hi", HI_OUT, 0);
    chk("rst_lo", LO_OUT, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    chk("busy_after_start", BUSY, 1);
    wait_done();
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    start_op(2'b11, 32'd7, 32'd0);
    wait_done();
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    @(posedge CLK); #1;
    mt_write(1'b1, 1'b0, 1'b1, 1'b1, 32'h1234);
    start_op(2'b00, 32'd9, 32'hFFFF_FFFC);
    repeat (4) @(posedge CLK);
    #1;
    noise();
    chk("busy_mt_hi", HI_OUT, 32'h1234);
    chk("busy_mt_lo", LO_OUT, m_e.lo);
    wait_done();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      if (op[1] && $urandom_range(0, 4) == 0) b = '0;
      start_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom));
      if (!(op[1] && b == 0) && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge CLK);
        #1;
        noise();
      end
      wait_done();
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CLK); #1;
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom));
      end
    end
    @(posedge CLK); #1;
    start_op(2'b10, 32'd1000, 32'd7);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    q.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_busy", BUSY, 0);
    chk("abort_hi", HI_OUT, 0);
    chk("abort_lo", LO_OUT, 0);
    repeat (40) @(posedge CLK);
    #1;
    chk("abort_no_done_idle", BUSY, 0);
    start_op(2'b00, 32'd5, 32'd6);
    wait_done();
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
